// File: rtl/tdm_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : tdm_adc_rx
// Description : Master-mode TDM receiver for a 4-channel audio ADC.
//               Generates bick/lrck from clk, deserializes the MSB-first
//               serial stream into four 16-bit two's-complement samples and
//               publishes them once per frame with a one-clk strobe and a
//               frame-rate sample_clk for the downstream calibration stage.
// Ports       : clk           system clock
//               rst_n         asynchronous active-low reset
//               enable        run/stop; low holds counters and bick idle
//               sdout         serial data from codec (changes on bick fall)
//               bick, lrck    registered codec bit clock / frame sync
//               sample_out0..3 published samples for slots 0..3
//               sample_valid  one-clk strobe when samples are published
//               sample_clk    rises one clk after publish, falls mid-frame
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_adc_rx #(
  parameter int BICK_HALF   = 1,
  parameter int SLOT_BITS   = 32,
  parameter int N_SLOTS     = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int DATA_DELAY  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   sdout,
  output logic                   bick,
  output logic                   lrck,
  output logic [SAMPLE_BITS-1:0] sample_out0,
  output logic [SAMPLE_BITS-1:0] sample_out1,
  output logic [SAMPLE_BITS-1:0] sample_out2,
  output logic [SAMPLE_BITS-1:0] sample_out3,
  output logic                   sample_valid,
  output logic                   sample_clk
);

  localparam int FRAME_BITS = SLOT_BITS * N_SLOTS;
  localparam int HALF_BITS  = FRAME_BITS / 2;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BICK_HALF > 1) ? $clog2(BICK_HALF) : 1;

  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_BITS - 1);
  localparam logic [BC_W-1:0]  BC_HALF  = BC_W'(HALF_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BICK_HALF - 1);

  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   bick_q, bick_d;
  logic                   lrck_q, lrck_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   sample_clk_q, sample_clk_d;
  logic [SAMPLE_BITS-1:0] shift_q      [N_SLOTS];
  logic [SAMPLE_BITS-1:0] shift_d      [N_SLOTS];
  logic [SAMPLE_BITS-1:0] sample_out_q [N_SLOTS];
  logic [SAMPLE_BITS-1:0] sample_out_d [N_SLOTS];

  logic div_wrap;
  logic rise_evt;
  logic fall_evt;

  // bick toggles when the divider wraps; the current bick level tells
  // whether that toggle is a rising or a falling edge of the bit clock.
  assign div_wrap = (div_cnt_q == DIV_LAST);
  assign rise_evt = enable & div_wrap & ~bick_q;
  assign fall_evt = enable & div_wrap &  bick_q;

  always_comb begin
    div_cnt_d      = div_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    bick_d         = bick_q;
    lrck_d         = lrck_q;
    sample_clk_d   = sample_clk_q;
    sample_valid_d = 1'b0;
    shift_d        = shift_q;
    sample_out_d   = sample_out_q;

    if (!enable) begin
      // Idle: discard any partial frame, published samples are kept.
      div_cnt_d    = '0;
      bit_cnt_d    = '0;
      bick_d       = 1'b0;
      lrck_d       = 1'b0;
      sample_clk_d = 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
        shift_d[s] = '0;
      end
    end else begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      if (div_wrap) begin
        bick_d = ~bick_q;
      end

      if (fall_evt) begin
        bit_cnt_d = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + 1'b1;
        lrck_d    = (bit_cnt_d < BC_HALF);
        if (bit_cnt_d == BC_HALF) begin
          sample_clk_d = 1'b0;
        end
      end

      if (rise_evt) begin
        // Codec changes sdout on the falling edge, so the rising edge is
        // the centre of the bit cell.
        for (int s = 0; s < N_SLOTS; s++) begin
          for (int k = 0; k < SAMPLE_BITS; k++) begin
            if (bit_cnt_q == BC_W'(s * SLOT_BITS + k + DATA_DELAY)) begin
              shift_d[s][SAMPLE_BITS-1-k] = sdout;
            end
          end
        end
        if (bit_cnt_q == BC_LAST) begin
          sample_out_d   = shift_q;
          sample_valid_d = 1'b1;
        end
      end

      // Rising one clk after the outputs change gives the downstream stage
      // a full clk of setup margin.
      if (sample_valid_q) begin
        sample_clk_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      bick_q         <= 1'b0;
      lrck_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_clk_q   <= 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
        shift_q[s]      <= '0;
        sample_out_q[s] <= '0;
      end
    end else begin
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      bick_q         <= bick_d;
      lrck_q         <= lrck_d;
      sample_valid_q <= sample_valid_d;
      sample_clk_q   <= sample_clk_d;
      shift_q        <= shift_d;
      sample_out_q   <= sample_out_d;
    end
  end

  assign bick         = bick_q;
  assign lrck         = lrck_q;
  assign sample_valid = sample_valid_q;
  assign sample_clk   = sample_clk_q;
  assign sample_out0  = sample_out_q[0];
  assign sample_out1  = sample_out_q[1];
  assign sample_out2  = sample_out_q[2];
  assign sample_out3  = sample_out_q[3];

endmodule
`default_nettype wire

// File: tb/tb_tdm_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_adc_rx
// Description : Self-checking bench for tdm_adc_rx. Two instances:
//               A (BICK_HALF=1, DATA_DELAY=1) and B (BICK_HALF=3,
//               DATA_DELAY=0), each fed by a codec model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_adc_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_a, en_b, sdout_a, sdout_b;
  logic bick_a, lrck_a, valid_a, sclk_a;
  logic bick_b, lrck_b, valid_b, sclk_b;
  logic [15:0] oa [4];
  logic [15:0] ob [4];
  logic [63:0] cv_a = '0;
  logic [63:0] cv_b = '0;
  int n_a, n_b;
  int errors = 0;
  int checks = 0;
  int prev [2][4];

  tdm_adc_rx #(.BICK_HALF(1), .DATA_DELAY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .sdout(sdout_a),
    .bick(bick_a), .lrck(lrck_a),
    .sample_out0(oa[0]), .sample_out1(oa[1]), .sample_out2(oa[2]), .sample_out3(oa[3]),
    .sample_valid(valid_a), .sample_clk(sclk_a)
  );

  tdm_adc_rx #(.BICK_HALF(3), .DATA_DELAY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .sdout(sdout_b),
    .bick(bick_b), .lrck(lrck_b),
    .sample_out0(ob[0]), .sample_out1(ob[1]), .sample_out2(ob[2]), .sample_out3(ob[3]),
    .sample_valid(valid_b), .sample_clk(sclk_b)
  );

  // Codec model: bit position p of the frame is driven after the p-th bick
  // falling edge. Ignored positions carry a pattern instead of zeros.
  function automatic logic codec_bit(input logic [63:0] vals, input int p, input int dd);
    int s;
    int off;
    s   = p / 32;
    off = (p % 32) - dd;
    if (off >= 0 && off < 16) return vals[s*16 + 15 - off];
    return p[0] ^ p[2];
  endfunction

  // n counts enabled clk edges; bick falls every 2*BICK_HALF of them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_a <= 0; sdout_a <= codec_bit(cv_a, 0, 1);
    end else if (en_a) begin
      n_a <= n_a + 1; sdout_a <= codec_bit(cv_a, ((n_a + 1) / 2) % 128, 1);
    end else begin
      n_a <= 0; sdout_a <= codec_bit(cv_a, 0, 1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_b <= 0; sdout_b <= codec_bit(cv_b, 0, 0);
    end else if (en_b) begin
      n_b <= n_b + 1; sdout_b <= codec_bit(cv_b, ((n_b + 1) / 6) % 128, 0);
    end else begin
      n_b <= 0; sdout_b <= codec_bit(cv_b, 0, 0);
    end
  end

  typedef struct {
    int          inst;
    bit          start;
    logic [15:0] in0, in1, in2, in3;
    int          e0, e1, e2, e3;
    int          gap;   // clk cycles in the observation window
    int          hi;    // sample_clk high cycles in the window
    int          lr;    // lrck high cycles in the window
  } vec_t;

  function automatic vec_t mk(input int inst, input bit start,
                              input logic [15:0] i0, i1, i2, i3,
                              input int e0, e1, e2, e3, gap, hi, lr);
    vec_t v;
    v.inst = inst; v.start = start;
    v.in0 = i0; v.in1 = i1; v.in2 = i2; v.in3 = i3;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    v.gap = gap; v.hi = hi; v.lr = lr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_out(input int inst, input int s);
    return inst != 0 ? int'($signed(ob[s])) : int'($signed(oa[s]));
  endfunction

  function automatic logic get_valid(input int inst);
    return inst != 0 ? valid_b : valid_a;
  endfunction

  function automatic logic get_sclk(input int inst);
    return inst != 0 ? sclk_b : sclk_a;
  endfunction

  function automatic logic get_lrck(input int inst);
    return inst != 0 ? lrck_b : lrck_a;
  endfunction

  // Runs one frame: optional (re)start, wait for the strobe while checking
  // that outputs hold, then check samples, window counts and the strobe tail.
  task automatic do_frame(input string tag, input vec_t v);
    int cyc = 0;
    int hi  = 0;
    int lr  = 0;
    bit held = 1'b1;
    bit got  = 1'b0;
    int exp_v [4];
    exp_v[0] = v.e0; exp_v[1] = v.e1; exp_v[2] = v.e2; exp_v[3] = v.e3;
    if (v.inst == 0) cv_a = {v.in3, v.in2, v.in1, v.in0};
    else             cv_b = {v.in3, v.in2, v.in1, v.in0};
    if (v.start) begin
      repeat (3) @(negedge clk);
      if (v.inst == 0) en_a = 1'b1; else en_b = 1'b1;
    end
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      cyc++;
      hi += int'(get_sclk(v.inst));
      lr += int'(get_lrck(v.inst));
      if (get_valid(v.inst)) got = 1'b1;
      else for (int s = 0; s < 4; s++) if (get_out(v.inst, s) != prev[v.inst][s]) held = 1'b0;
    end
    check({tag, " strobe_seen"}, int'(got), 1);
    if (!got) return;
    check({tag, " hold"}, int'(held), 1);
    check({tag, " gap"}, cyc, v.gap);
    check({tag, " sclk_hi"}, hi, v.hi);
    check({tag, " lrck_hi"}, lr, v.lr);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s out%0d", tag, s), get_out(v.inst, s), exp_v[s]);
      prev[v.inst][s] = exp_v[s];
    end
    check({tag, " sclk_at_strobe"}, int'(get_sclk(v.inst)), 0);
    @(negedge clk);
    check({tag, " strobe_tail"}, int'({get_valid(v.inst), get_sclk(v.inst)}), 1);
  endtask

  vec_t va [10];
  vec_t vb [3];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit idle_ok;
    bit quiet;
    va[0] = mk(0, 1, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF, 4660, -32768, 32767, -1, 255, 0, 126);
    va[1] = mk(0, 0, 16'h0001, 16'hFFFE, 16'h4000, 16'hC000, 1, -2, 16384, -16384, 255, 127, 127);
    va[2] = mk(0, 0, 16'h0002, 16'hFFFD, 16'h4001, 16'hC001, 2, -3, 16385, -16383, 255, 127, 127);
    va[3] = mk(0, 0, 16'h0003, 16'hFFFC, 16'h4002, 16'hC002, 3, -4, 16386, -16382, 255, 127, 127);
    va[4] = mk(0, 0, 16'h0004, 16'hFFFB, 16'h4003, 16'hC003, 4, -5, 16387, -16381, 255, 127, 127);
    va[5] = mk(0, 0, 16'h0005, 16'hFFFA, 16'h4004, 16'hC004, 5, -6, 16388, -16380, 255, 127, 127);
    va[6] = mk(0, 0, 16'h0006, 16'hFFF9, 16'h4005, 16'hC005, 6, -7, 16389, -16379, 255, 127, 127);
    va[7] = mk(0, 0, 16'h0007, 16'hFFF8, 16'h4006, 16'hC006, 7, -8, 16390, -16378, 255, 127, 127);
    va[8] = mk(0, 0, 16'h0008, 16'hFFF7, 16'h4007, 16'hC007, 8, -9, 16391, -16377, 255, 127, 127);
    va[9] = mk(0, 0, 16'h0009, 16'hFFF6, 16'h4008, 16'hC008, 9, -10, 16392, -16376, 255, 127, 127);
    vb[0] = mk(1, 1, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, -1, 1, -32768, 32767, 765, 0, 378);
    vb[1] = mk(1, 0, 16'hDEAD, 16'hBEEF, 16'h0100, 16'h00FF, -8531, -16657, 256, 255, 767, 385, 384);
    vb[2] = mk(1, 0, 16'h0000, 16'h4000, 16'hA5A5, 16'h5A5A, 0, 16384, -23131, 23130, 767, 385, 384);

    for (int i = 0; i < 2; i++) for (int s = 0; s < 4; s++) prev[i][s] = 0;

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", int'({bick_a, lrck_a, valid_a, sclk_a, oa[0], oa[1], oa[2], oa[3]} != '0), 0);
    check("reset_b", int'({bick_b, lrck_b, valid_b, sclk_b, ob[0], ob[1], ob[2], ob[3]} != '0), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_frame($sformatf("a%0d", i), va[i]);

    // Drop enable around bit 70 of the next frame.
    repeat (140) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    check("disable_idle", int'({bick_a, lrck_a, sclk_a, valid_a}), 0);
    quiet = 1'b1;
    repeat (19) begin
      @(negedge clk);
      if (valid_a) quiet = 1'b0;
      for (int s = 0; s < 4; s++) if (get_out(0, s) != prev[0][s]) quiet = 1'b0;
    end
    check("disable_hold", int'(quiet), 1);
    do_frame("a_reen", mk(0, 1, 16'h0ABC, 16'hF00F, 16'h0000, 16'h8001,
                          2748, -4081, 0, -32767, 255, 0, 126));

    // Asynchronous reset in the middle of a frame.
    repeat (20) @(negedge clk);
    check("pre_reset_active", int'({lrck_a, sclk_a}), 3);
    #1 rst_n = 1'b0;
    #1;
    idle_ok = ({bick_a, lrck_a, valid_a, sclk_a, oa[0], oa[1], oa[2], oa[3]} == '0);
    check("async_reset", int'(idle_ok), 1);
    en_a = 1'b0;
    for (int s = 0; s < 4; s++) prev[0][s] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_frame("a_rst", mk(0, 1, 16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA,
                         3855, -3856, 21845, -21846, 255, 0, 126));
    en_a = 1'b0;

    for (int i = 0; i < 3; i++) do_frame($sformatf("b%0d", i), vb[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
